// File: rtl/sine_pwm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sine_pwm_sequencer: steps a sine-table angle, one PWM frame per sample.  |
// | Option SEQ_ONESHOT_EN: stop after one period, re-arm once enable drops.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sine_pwm_sequencer #(
  parameter int TABLE_LEN = 47,
  parameter int PWM_MAX   = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] rate_div,
  output logic [7:0]  angle_output,
  input  logic [7:0]  sine_input,
  output logic        pwm_out,
  output logic        busy,
  output logic        period_done
);

  localparam logic [7:0] CNT_LAST   = 8'(PWM_MAX - 1);
  localparam logic [7:0] CNT_STEP   = 8'(PWM_MAX - 2);
  localparam logic [7:0] ANGLE_LAST = 8'(TABLE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  angle_q, angle_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] step_div_q, step_div_d;
  logic        period_done_q, period_done_d;
  logic        armed_q, armed_d;

  logic frame_end;
  logic step_due;
  logic wrap_stop;

  assign frame_end = (pwm_cnt_q == CNT_LAST);
  assign step_due  = (frame_cnt_q == step_div_q);

  // period_done_q is high exactly on the last clock of the frame that wrapped,
  // so it doubles as the one-shot end-of-period marker.
`ifdef SEQ_ONESHOT_EN
  assign wrap_stop = period_done_q;
`else
  assign wrap_stop = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pwm_cnt_d     = pwm_cnt_q;
    angle_d       = angle_q;
    duty_d        = duty_q;
    frame_cnt_d   = frame_cnt_q;
    step_div_d    = step_div_q;
    period_done_d = 1'b0;
    armed_d       = armed_q;

    case (state_q)
      IDLE: begin
        pwm_cnt_d   = '0;
        angle_d     = '0;
        frame_cnt_d = '0;
        if (!enable) armed_d = 1'b1;
        if (enable && armed_q) begin
          state_d    = RUN;
          duty_d     = sine_input;
          step_div_d = rate_div;
        end
      end

      RUN, DRAIN: begin
        pwm_cnt_d = frame_end ? '0 : pwm_cnt_q + 8'd1;
        // Advance one clock before frame end so the table sample is ready
        // for the duty reload on the following edge.
        if (step_due && (pwm_cnt_q == CNT_STEP)) begin
          angle_d       = (angle_q == ANGLE_LAST) ? '0 : angle_q + 8'd1;
          period_done_d = (angle_q == ANGLE_LAST);
        end
        if (!enable) state_d = DRAIN;
        if (frame_end) begin
          duty_d = sine_input;
          if (step_due) begin
            frame_cnt_d = '0;
            step_div_d  = rate_div;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          if (!enable || wrap_stop) begin
            state_d     = IDLE;
            angle_d     = '0;
            frame_cnt_d = '0;
            if (wrap_stop) armed_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pwm_cnt_q     <= '0;
      angle_q       <= '0;
      duty_q        <= '0;
      frame_cnt_q   <= '0;
      step_div_q    <= '0;
      period_done_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      pwm_cnt_q     <= pwm_cnt_d;
      angle_q       <= angle_d;
      duty_q        <= duty_d;
      frame_cnt_q   <= frame_cnt_d;
      step_div_q    <= step_div_d;
      period_done_q <= period_done_d;
      armed_q       <= armed_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign pwm_out      = busy && (pwm_cnt_q < duty_q);
  assign angle_output = angle_q;
  assign period_done  = period_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_pwm_sequencer.sv
`default_nettype none
// Scoreboard bench: a frame-level reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_sine_pwm_sequencer;
  localparam int TABLE_LEN = 47;
  localparam int PWM_MAX   = 100;
`ifdef SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic [7:0]  angle_output;
  logic [7:0]  sine_input;
  logic        pwm_out;
  logic        busy;
  logic        period_done;
  logic [7:0]  lut [256];

  int compared    = 0;
  int mismatched  = 0;
  int timeouts    = 0;
  int exp_spacing = 0;

  sine_pwm_sequencer #(.TABLE_LEN(TABLE_LEN), .PWM_MAX(PWM_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rate_div    (rate_div),
    .angle_output(angle_output),
    .sine_input  (sine_input),
    .pwm_out     (pwm_out),
    .busy        (busy),
    .period_done (period_done)
  );

  assign sine_input = lut[angle_output];

  always #5 clk = ~clk;

  // Reference model: total steps taken since start, position in frame,
  // frames spent on the current angle and the hold length for this angle.
  logic [10:0] exp_q[$];
  bit m_busy = 0, m_armed = 1, m_pd = 0, m_wrap = 0, m_due = 0, m_stop = 0;
  int m_pos = 0, m_steps = 0, m_frames = 0, m_hold = 0, m_duty = 0;

  function automatic logic [10:0] expected();
    int ang;
    ang = m_steps % TABLE_LEN;
    return {m_busy, (m_busy && (m_pos < m_duty)), m_pd, 8'(ang)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_armed = 1; m_pd = 0; m_wrap = 0;
      m_pos = 0; m_steps = 0; m_frames = 0; m_hold = 0; m_duty = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_pd = 0;
      if (ONESHOT && !enable) m_armed = 1;
      if (enable && m_armed) begin
        m_busy = 1; m_pos = 0; m_steps = 0; m_frames = 0; m_wrap = 0;
        m_hold = int'(rate_div);
        m_duty = int'(lut[0]);
      end
    end else begin
      m_due = (m_frames == m_hold);
      m_pd  = 0;
      if (m_due && m_pos == PWM_MAX - 2) begin
        m_steps++;
        m_pd = ((m_steps % TABLE_LEN) == 0);
        if (m_pd) m_wrap = 1;
      end
      if (m_pos == PWM_MAX - 1) begin
        m_stop = !enable;
        if (ONESHOT && m_wrap) begin
          m_stop  = 1;
          m_armed = 0;
        end
        m_wrap = 0;
        m_pos  = 0;
        if (m_stop) begin
          m_busy = 0; m_steps = 0; m_frames = 0;
        end else begin
          m_duty = int'(lut[m_steps % TABLE_LEN]);
          if (m_due) begin
            m_frames = 0;
            m_hold   = int'(rate_div);
          end else begin
            m_frames++;
          end
        end
      end else begin
        m_pos++;
      end
    end
    exp_q.push_back(expected());
  end

  // Monitor: the only process that steps the comparison counters.
  int cyc = 0, last_pd = -1, seen_timeouts = 0;
  always @(negedge clk) begin
    logic [10:0] g_val, e_val;
    cyc++;
    if (exp_q.size() != 0) begin
      e_val = exp_q.pop_front();
      g_val = {busy, pwm_out, period_done, angle_output};
      compared++;
      if (g_val !== e_val) begin
        mismatched++;
        $display("FAIL outputs cyc %0d: got busy/pwm/pd/angle=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 cyc, g_val[10], g_val[9], g_val[8], g_val[7:0],
                 e_val[10], e_val[9], e_val[8], e_val[7:0]);
      end
    end
    if (exp_spacing == 0) begin
      last_pd = -1;
    end else if (period_done === 1'b1) begin
      if (last_pd >= 0) begin
        compared++;
        if (cyc - last_pd != exp_spacing) begin
          mismatched++;
          $display("FAIL period_spacing: got %0d clocks want %0d", cyc - last_pd, exp_spacing);
        end
      end
      last_pd = cyc;
    end
    if (timeouts != seen_timeouts) begin
      compared++;
      mismatched++;
      $display("FAIL wait_timeout: got %0d expired waits want 0", timeouts);
      seen_timeouts = timeouts;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Waits for the model to reach a frame position (and angle, unless ang < 0).
  task automatic wait_pos(input int pos, input int ang, input int budget);
    int k;
    k = 0;
    while (!(m_busy && m_pos == pos && (ang < 0 || (m_steps % TABLE_LEN) == ang))
           && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) timeouts++;
  endtask

  task automatic fill_lut(input int lo, input int hi);
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(hi, lo));
  endtask

  initial begin
    fill_lut(0, 99);
    lut[0] = 8'd50;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Continuous run, rate_div=0: two full periods with spacing checked.
    exp_spacing = TABLE_LEN * PWM_MAX;
    enable = 1'b1;
    tick(2 * TABLE_LEN * PWM_MAX + 300);
    exp_spacing = 0;

    // Drop at 30, re-raise at 60: run continues.
    wait_pos(30, -1, 200); enable = 1'b0;
    wait_pos(60, -1, 200); enable = 1'b1;
    tick(300);

    // Drop at 30 and stay low: frame completes, then idle.
    wait_pos(30, -1, 200); enable = 1'b0;
    tick(250);

    // Toggle during drain: only the frame-end value matters.
    enable = 1'b1; tick(150);
    wait_pos(20, -1, 200); enable = 1'b0;
    wait_pos(50, -1, 200); enable = 1'b1;
    wait_pos(80, -1, 200); enable = 1'b0;
    tick(200);

    // Saturated and zero duty.
    fill_lut(120, 120); enable = 1'b1; tick(300);
    fill_lut(0, 0); tick(300);
    fill_lut(0, 130);

    // Slower stepping, including rate changes mid-step.
    rate_div = 16'd2;
    tick(3 * PWM_MAX * 6);
    repeat (8) begin
      wait_pos(int'($urandom_range(PWM_MAX - 1, 0)), -1, 300);
      rate_div = 16'($urandom_range(3, 0));
      tick(int'($urandom_range(600, 100)));
    end

    // Reset at angle 20, pwm_cnt 40; restart from angle 0 with a fresh lut[0].
    rate_div = 16'd0;
    wait_pos(40, 20, 6000);
    reset = 1'b1;
    tick(2);
    lut[0] = 8'($urandom_range(130, 0));
    reset = 1'b0;
    tick(400);

    // Randomised mix of enable, rate, table contents and short resets.
    repeat (60) begin
      enable   = ($urandom_range(9, 0) != 0);
      rate_div = 16'($urandom_range(2, 0));
      lut[$urandom_range(TABLE_LEN - 1, 0)] = 8'($urandom_range(130, 0));
      if ($urandom_range(19, 0) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(int'($urandom_range(400, 20)));
    end

    enable = 1'b0;
    tick(PWM_MAX + 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
